rca_seq: RTL and testbench

Parametrised multi-cycle ripple-carry adder. It adds two WIDTH-bit operands CHUNK bits per clock, holding the inter-chunk carry in a register. This trades latency for area on wide datapaths where a full-width ripple chain is too long for one cycle. It sits in the datapath as the wide-operand successor of the 4-bit combinational adder, with a start/done handshake toward the controlling FSM.

---
 rtl/rca_seq.sv | 112 +++++++++++
 tb/tb_rca_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq.sv
// Multi-cycle ripple-carry adder: adds WIDTH-bit operands CHUNK bits per clock with a start/done handshake.
// Optional signed-overflow output `ovf` is built when RCA_SEQ_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, result of last op held on s/co
// RUN   | one CHUNK-bit slice added per cycle, carry held between slices
// DONE  | one-cycle done pulse; start here begins a back-to-back op
module rca_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy,
  output logic             done
`ifdef RCA_SEQ_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, co_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   slice;
  logic             accept, last;

  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    last   = (cnt == CW'(NCHUNK - 1));
    a_c    = '0;
    b_c    = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        a_c = a_q[i*CHUNK +: CHUNK];
        b_c = b_q[i*CHUNK +: CHUNK];
      end
    end
    slice = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The entry carry register is loaded with ci so chunk 0 needs no special case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt     <= '0;
`ifdef RCA_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      s_q     <= '0;
      carry_q <= ci;
      co_q    <= 1'b0;
      cnt     <= '0;
`ifdef RCA_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (state == RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (cnt == CW'(i)) s_q[i*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
      end
      carry_q <= slice[CHUNK];
      cnt     <= cnt + 1'b1;
      if (last) begin
        co_q <= slice[CHUNK];
`ifdef RCA_SEQ_OVF_EN
        // Same-sign operands giving a different-sign sum == carry-in(MSB) ^ carry-out(MSB).
        ovf  <= (a_c[CHUNK-1] ~^ b_c[CHUNK-1]) & (slice[CHUNK-1] ^ a_c[CHUNK-1]);
`endif
      end
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rca_seq.sv
// Self-checking bench for rca_seq: cycle model for the 16/4 instance, result checks for 8/8 and 32/8.
// Build with RCA_SEQ_OVF_EN defined to also check ovf.
module tb_rca_seq;

  logic clk = 1'b0;
  logic reset, start16, start_x, ci;
  logic [15:0] a16, b16, s16;
  logic [7:0]  a8, b8, s8;
  logic [31:0] a32, b32, s32;
  logic co16, busy16, done16, co8, busy8, done8, co32, busy32, done32;
`ifdef RCA_SEQ_OVF_EN
  logic ovf16, ovf8, ovf32;
`endif

  always #5 clk = ~clk;

  rca_seq #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .ci(ci),
    .s(s16), .co(co16), .busy(busy16), .done(done16)
`ifdef RCA_SEQ_OVF_EN
    ,.ovf(ovf16)
`endif
  );

  rca_seq #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .reset(reset), .start(start_x), .a(a8), .b(b8), .ci(ci),
    .s(s8), .co(co8), .busy(busy8), .done(done8)
`ifdef RCA_SEQ_OVF_EN
    ,.ovf(ovf8)
`endif
  );

  rca_seq #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .reset(reset), .start(start_x), .a(a32), .b(b32), .ci(ci),
    .s(s32), .co(co32), .busy(busy32), .done(done32)
`ifdef RCA_SEQ_OVF_EN
    ,.ovf(ovf32)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the 16/4 instance: cycles-remaining counter plus the arithmetic result.
  int          m_rem;
  bit          m_done;
  logic [15:0] m_s, p_s;
  logic        m_co, m_ovf, p_co, p_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem = 0; m_done = 0; m_s = '0; m_co = 0; m_ovf = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
      if (m_done) begin m_s = p_s; m_co = p_co; m_ovf = p_ovf; end
    end else begin
      m_done = 0;
      if (start16) begin
        {p_co, p_s} = {1'b0, a16} + {1'b0, b16} + {16'd0, ci};
        p_ovf = (a16[15] == b16[15]) && (p_s[15] != a16[15]);
        m_rem = 4;
        m_s = '0; m_co = 0; m_ovf = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("u16_busy", busy16, m_rem > 0);
    check("u16_done", done16, m_done);
    if (m_rem == 0) begin
      check("u16_s", s16, m_s);
      check("u16_co", co16, m_co);
`ifdef RCA_SEQ_OVF_EN
      check("u16_ovf", ovf16, m_ovf);
`endif
    end
  end

  // 8/8 and 32/8 instances: every done must match an outstanding start.
  int          n_start8 = 0, n_done8 = 0, n_start32 = 0, n_done32 = 0;
  logic [8:0]  e8;
  logic [32:0] e32;
  logic        e8_ovf, e32_ovf;

  always @(negedge clk) begin
    if (!reset && done8) begin
      check("u8_done_without_start", done8, n_start8 > n_done8);
      check("u8_sum", {co8, s8}, e8);
`ifdef RCA_SEQ_OVF_EN
      check("u8_ovf", ovf8, e8_ovf);
`endif
      n_done8++;
    end
    if (!reset && done32) begin
      check("u32_done_without_start", done32, n_start32 > n_done32);
      check("u32_sum", {co32, s32}, e32);
`ifdef RCA_SEQ_OVF_EN
      check("u32_ovf", ovf32, e32_ovf);
`endif
      n_done32++;
    end
  end

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input logic [15:0] es, input logic eco, input string name);
    int nb;
    bit got;
    @(posedge clk); #1;
    a16 = ta; b16 = tb_v; ci = tc; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done16) got = 1;
      else if (busy16) nb++;
    end
    check({name, "_done_seen"}, got, 1);
    check({name, "_busy_cycles"}, nb, 4);
    check({name, "_s"}, s16, es);
    check({name, "_co"}, co16, eco);
  endtask

  initial begin
    int  n;
    bit  got;
    bit  settled;
    reset = 1; start16 = 0; start_x = 0; ci = 0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s", s16, 16'h0000);
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    reset = 0;

    // Reset in the middle of RUN abandons the op.
    @(posedge clk); #1;
    a16 = 16'h1234; b16 = 16'h4321; ci = 0; start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    #1;
    check("t1_s", s16, 16'h0000);
    check("t1_co", co16, 0);
    check("t1_busy", busy16, 0);
    check("t1_done", done16, 0);
    @(negedge clk); #2;
    reset = 0;
    got = 0;
    repeat (8) begin @(negedge clk); if (done16) got = 1; end
    check("t1_no_done_after_reset", got, 0);

    op16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "t2");
    op16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "t3");
`ifdef RCA_SEQ_OVF_EN
    check("t3_ovf", ovf16, 0);
`endif
    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "t4a");
`ifdef RCA_SEQ_OVF_EN
    check("t4a_ovf", ovf16, 1);
`endif
    op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "t4b");
`ifdef RCA_SEQ_OVF_EN
    check("t4b_ovf", ovf16, 1);
`endif

    // start held high, operands toggled during RUN, then back-to-back op from DONE.
    @(posedge clk); #1;
    a16 = 16'h1111; b16 = 16'h2222; ci = 0; start16 = 1;
    @(posedge clk);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done16) got = 1;
      else begin a16 = ~a16; b16 = b16 + 16'h0101; end
    end
    check("t5_first_done_seen", got, 1);
    check("t5_first_s", s16, 16'h3333);
    check("t5_first_co", co16, 0);
    a16 = 16'h00FF; b16 = 16'h0001; ci = 0;
    @(posedge clk); #1;
    start16 = 0;
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (done16) got = 1;
    end
    check("t5_second_done_gap", n, 5);
    check("t5_second_s", s16, 16'h0100);
    check("t5_second_co", co16, 0);

    // Random operands on all three widths.
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] ra, rb;
      logic        rc;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      a32 = ra; b32 = rb; a16 = ra[15:0]; b16 = rb[15:0]; a8 = ra[7:0]; b8 = rb[7:0]; ci = rc;
      e8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'd0, rc};
      e32 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      e8_ovf  = (ra[7] == rb[7]) && (e8[7] != ra[7]);
      e32_ovf = (ra[31] == rb[31]) && (e32[31] != ra[31]);
      start16 = 1; start_x = 1;
      @(posedge clk); #1;
      start16 = 0; start_x = 0;
      n_start8++; n_start32++;
      settled = 0;
      for (int i = 0; i < 30 && !settled; i++) begin
        @(negedge clk); #1;
        settled = (n_done8 == n_start8) && (n_done32 == n_start32) && !busy16 && !busy8 && !busy32;
      end
      check("rnd_op_complete", settled, 1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
